// File: rtl/ysyx_22040175_ifu_pkg.sv
// Shared definitions for the instruction fetch unit: default geometry,
// FSM state encoding and the layout of a queue entry.
package ysyx_22040175_ifu_pkg;

  localparam int unsigned IFU_ADDR_W   = 64;
  localparam int unsigned IFU_INST_W   = 32;
  localparam logic [63:0] IFU_RESET_PC = 64'h8000_0000;
  localparam int unsigned IFU_DEPTH    = 2;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_STOP = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    WAIT = ST_WAIT,
    STOP = ST_STOP
  } ifu_state_e;

  // Queue entry layout, LSB first: {inst, pc, fault}
  localparam int unsigned ENTRY_FAULT_BIT = 0;
  localparam int unsigned ENTRY_PC_LSB    = 1;

  function automatic int unsigned entry_inst_lsb(input int unsigned addr_w);
    return ENTRY_PC_LSB + addr_w;
  endfunction

  function automatic int unsigned entry_width(input int unsigned addr_w,
                                              input int unsigned inst_w);
    return inst_w + addr_w + 1;
  endfunction

endpackage

// File: rtl/ysyx_22040175_ifu_fifo.sv
// DEPTH-entry synchronous FIFO holding fetched instruction entries.
// Ports:
//   clk, rst_n  clock / async active-low reset
//   flush       empties the queue (highest priority)
//   push        write push_data at the tail (ignored when full without a pop)
//   pop         drop the head entry (ignored when empty)
//   head        entry at the head of the queue
//   count       number of valid entries
module ysyx_22040175_ifu_fifo
  import ysyx_22040175_ifu_pkg::*;
#(
  parameter int unsigned WIDTH = entry_width(IFU_ADDR_W, IFU_INST_W),
  parameter int unsigned DEPTH = IFU_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  // A push into a full queue is legal only when the head leaves in the same cycle
  always_comb begin
    do_pop  = pop && (count_q != '0);
    do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
  end

  // Storage and pointers; DEPTH is a power of two so pointers wrap naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ysyx_22040175_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one word request at a
// time to instruction memory, queues responses and hands them to decode.
// Redirects flush the queue and drop any in-flight response; a misaligned
// redirect target or a faulting response parks the unit in STOP.
// Ports:
//   clk, rst_n                       clock / async active-low reset
//   redirect_valid, redirect_pc      PC redirect from execute
//   halt                             level, blocks new requests
//   imem_req_valid/ready/addr        fetch request handshake
//   imem_rsp_valid/data/err          fetch response (always accepted)
//   inst_valid/ready, inst,
//   inst_pc, inst_fault              queue head towards decode
module ysyx_22040175_ifu
  import ysyx_22040175_ifu_pkg::*;
#(
  parameter int unsigned        ADDR_W   = IFU_ADDR_W,
  parameter int unsigned        INST_W   = IFU_INST_W,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(IFU_RESET_PC),
  parameter int unsigned        DEPTH    = IFU_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              imem_rsp_err,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault
);

  localparam int unsigned CNT_W    = $clog2(DEPTH) + 1;
  localparam int unsigned ENT_W    = entry_width(ADDR_W, INST_W);
  localparam int unsigned INST_LSB = entry_inst_lsb(ADDR_W);

  ifu_state_e        state_q,       state_d;
  logic [ADDR_W-1:0] fetch_pc_q,    fetch_pc_d;
  logic [ADDR_W-1:0] req_pc_q,      req_pc_d;
  logic [ADDR_W-1:0] fault_pc_q,    fault_pc_d;
  logic              outstanding_q, outstanding_d;
  logic              drop_q,        drop_d;
  logic              misalign_q,    misalign_d;
  logic              req_valid_q,   req_valid_d;

  logic              req_fire;
  logic              rsp_take;
  logic              misaligned;
  logic              push;
  logic              pop;
  logic [ENT_W-1:0]  push_data;
  logic [ENT_W-1:0]  head;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  count_next;

  ysyx_22040175_ifu_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  // Handshake qualifiers
  always_comb begin
    req_fire   = req_valid_q && imem_req_ready;
    rsp_take   = outstanding_q && imem_rsp_valid;
    misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
    pop        = inst_valid && inst_ready;
  end

  // Next-state, queue-push and request-valid logic
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    fault_pc_d    = fault_pc_q;
    outstanding_d = outstanding_q;
    drop_d        = drop_q;
    misalign_d    = 1'b0;
    req_valid_d   = 1'b0;
    push          = 1'b0;
    push_data     = '0;
    count_next    = '0;

    case (state_q)
      IDLE:    state_d = REQ;
      REQ:     if (req_fire) state_d = WAIT;
      WAIT:    if (rsp_take) state_d = (imem_rsp_err && !drop_q) ? STOP : REQ;
      STOP:    state_d = STOP;
      default: state_d = IDLE;
    endcase

    if (req_fire) begin
      fetch_pc_d    = fetch_pc_q + ADDR_W'(4);
      req_pc_d      = fetch_pc_q;
      outstanding_d = 1'b1;
    end

    // Response retires the outstanding request; stale ones are discarded
    if (rsp_take) begin
      outstanding_d = 1'b0;
      drop_d        = 1'b0;
      if (!drop_q) begin
        push                                 = 1'b1;
        push_data[ENTRY_FAULT_BIT]           = imem_rsp_err;
        push_data[ENTRY_PC_LSB +: ADDR_W]    = req_pc_q;
        push_data[INST_LSB +: INST_W]        = imem_rsp_data;
      end
    end

    // Deferred fault entry for a misaligned redirect target
    if (misalign_q) begin
      push                              = 1'b1;
      push_data                         = '0;
      push_data[ENTRY_FAULT_BIT]        = 1'b1;
      push_data[ENTRY_PC_LSB +: ADDR_W] = fault_pc_q;
    end

    // Redirect overrides everything: flush, retarget, mark in-flight data stale
    if (redirect_valid) begin
      push          = 1'b0;
      push_data     = '0;
      fetch_pc_d    = redirect_pc;
      outstanding_d = (outstanding_q && !imem_rsp_valid) || req_fire;
      drop_d        = outstanding_d;
      if (misaligned) begin
        misalign_d = 1'b1;
        fault_pc_d = redirect_pc;
        state_d    = STOP;
      end else begin
        state_d = outstanding_d ? WAIT : REQ;
      end
    end

    count_next = redirect_valid ? '0 : (count + CNT_W'(push) - CNT_W'(pop));

    // An unaccepted request holds until ready unless a redirect retargets it
    if (state_d == REQ) begin
      if (req_valid_q && !req_fire && !redirect_valid) begin
        req_valid_d = 1'b1;
      end else begin
        req_valid_d = !halt && (count_next < CNT_W'(DEPTH));
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      fault_pc_q    <= '0;
      outstanding_q <= 1'b0;
      drop_q        <= 1'b0;
      misalign_q    <= 1'b0;
      req_valid_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      fault_pc_q    <= fault_pc_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;
      misalign_q    <= misalign_d;
      req_valid_q   <= req_valid_d;
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = (count != '0);
  assign inst_fault     = head[ENTRY_FAULT_BIT];
  assign inst_pc        = head[ENTRY_PC_LSB +: ADDR_W];
  assign inst           = head[INST_LSB +: INST_W];

endmodule
